// File: rtl/ulpb_pkg.sv
// Shared widths and FSM state encodings for the ULPB layer interface.
package ulpb_pkg;

    localparam int ULPB_ADDR_WIDTH = 8;
    localparam int ULPB_DATA_WIDTH = 32;

    localparam logic [1:0] TX_IDLE    = 2'd0;
    localparam logic [1:0] TX_REQ     = 2'd1;
    localparam logic [1:0] TX_RELEASE = 2'd2;

    localparam logic RX_IDLE = 1'b0;
    localparam logic RX_ACK  = 1'b1;

endpackage

// File: rtl/ulpb_fifo.sv
// Small synchronous FIFO holding outgoing messages; exposes its occupancy count.
// A push while full is dropped, and a pop while empty is ignored.
module ulpb_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL_COUNT);
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ulpb_layer_if.sv
// ULPB node layer interface: queues user messages into a strict 4-phase
// transmit handshake and captures node-delivered messages into a
// valid/ready user port, with the two directions fully independent.
module ulpb_layer_if
    import ulpb_pkg::*;
#(
    parameter int ADDR_WIDTH = ULPB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ULPB_DATA_WIDTH,
    parameter int TX_DEPTH   = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,

    input  logic                      TX_VALID,
    input  logic [ADDR_WIDTH-1:0]     TX_ADDR,
    input  logic [DATA_WIDTH-1:0]     TX_DATA,
    output logic                      TX_READY,

    output logic                      RX_VALID,
    output logic [ADDR_WIDTH-1:0]     RX_ADDR,
    output logic [DATA_WIDTH-1:0]     RX_DATA,
    input  logic                      RX_READY,

    output logic [ADDR_WIDTH-1:0]     ADDR_IN,
    output logic [DATA_WIDTH-1:0]     DATA_IN,
    output logic                      REQ_TX,
    input  logic                      ACK_TX,

    input  logic [ADDR_WIDTH-1:0]     ADDR_OUT,
    input  logic [DATA_WIDTH-1:0]     DATA_OUT,
    input  logic                      REQ_RX,
    output logic                      ACK_RX,

    output logic [$clog2(TX_DEPTH):0] TX_COUNT
);

    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam int MW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CW-1:0] FULL_COUNT = CW'(TX_DEPTH);

    logic [1:0]            tx_state;
    logic                  rx_state;
    logic                  tx_pop;
    logic [MW-1:0]         head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    // Ready comes straight from the registered count so it is glitch-free.
    assign TX_READY  = (TX_COUNT != FULL_COUNT);
    assign head_addr = head[MW-1:DATA_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

    // The head entry stays queued until the node acknowledges it.
    assign tx_pop    = (tx_state == TX_REQ) && ACK_TX;

    ulpb_fifo #(
        .WIDTH (MW),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (TX_VALID),
        .wdata ({TX_ADDR, TX_DATA}),
        .pop   (tx_pop),
        .rdata (head),
        .count (TX_COUNT)
    );

    // Transmit handshake: present head, wait for ack, then wait for ack release.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_state <= TX_IDLE;
            REQ_TX   <= 1'b0;
            ADDR_IN  <= '0;
            DATA_IN  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (TX_COUNT != '0) begin
                        ADDR_IN  <= head_addr;
                        DATA_IN  <= head_data;
                        REQ_TX   <= 1'b1;
                        tx_state <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (ACK_TX) begin
                        REQ_TX   <= 1'b0;
                        tx_state <= TX_RELEASE;
                    end
                end
                TX_RELEASE: begin
                    if (!ACK_TX) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    REQ_TX   <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Receive handshake: ack only when the user slot is free or being drained this edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_state <= RX_IDLE;
            ACK_RX   <= 1'b0;
            RX_VALID <= 1'b0;
            RX_ADDR  <= '0;
            RX_DATA  <= '0;
        end else begin
            if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end
            if (rx_state == RX_IDLE) begin
                if (REQ_RX && (!RX_VALID || RX_READY)) begin
                    RX_ADDR  <= ADDR_OUT;
                    RX_DATA  <= DATA_OUT;
                    RX_VALID <= 1'b1;
                    ACK_RX   <= 1'b1;
                    rx_state <= RX_ACK;
                end
            end else begin
                if (!REQ_RX) begin
                    ACK_RX   <= 1'b0;
                    rx_state <= RX_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ulpb_layer_if.sv
// Directed bench for ulpb_layer_if with hand-computed expected values.
module tb_ulpb_layer_if;

    logic        CLK;
    logic        RESET;
    logic        TX_VALID;
    logic [7:0]  TX_ADDR;
    logic [31:0] TX_DATA;
    logic        TX_READY;
    logic        RX_VALID;
    logic [7:0]  RX_ADDR;
    logic [31:0] RX_DATA;
    logic        RX_READY;
    logic [7:0]  ADDR_IN;
    logic [31:0] DATA_IN;
    logic        REQ_TX;
    logic        ACK_TX;
    logic [7:0]  ADDR_OUT;
    logic [31:0] DATA_OUT;
    logic        REQ_RX;
    logic        ACK_RX;
    logic [2:0]  TX_COUNT;

    int vectorCount = 0;
    int errorCount  = 0;

    ulpb_layer_if #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .TX_DEPTH   (4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .TX_VALID (TX_VALID),
        .TX_ADDR  (TX_ADDR),
        .TX_DATA  (TX_DATA),
        .TX_READY (TX_READY),
        .RX_VALID (RX_VALID),
        .RX_ADDR  (RX_ADDR),
        .RX_DATA  (RX_DATA),
        .RX_READY (RX_READY),
        .ADDR_IN  (ADDR_IN),
        .DATA_IN  (DATA_IN),
        .REQ_TX   (REQ_TX),
        .ACK_TX   (ACK_TX),
        .ADDR_OUT (ADDR_OUT),
        .DATA_OUT (DATA_OUT),
        .REQ_RX   (REQ_RX),
        .ACK_RX   (ACK_RX),
        .TX_COUNT (TX_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic tv, input logic [7:0] ta, input logic [31:0] td);
        TX_VALID = tv;
        TX_ADDR  = ta;
        TX_DATA  = td;
    endtask

    task automatic waitReqTx(input logic lvl, input string tag);
        int n;
        n = 0;
        while (REQ_TX !== lvl && n < 20) begin
            step();
            n++;
        end
        checkOutput(tag, REQ_TX, lvl);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " REQ_TX"},   REQ_TX,   0);
        checkOutput({tag, " ACK_RX"},   ACK_RX,   0);
        checkOutput({tag, " RX_VALID"}, RX_VALID, 0);
        checkOutput({tag, " ADDR_IN"},  ADDR_IN,  0);
        checkOutput({tag, " DATA_IN"},  DATA_IN,  0);
        checkOutput({tag, " RX_ADDR"},  RX_ADDR,  0);
        checkOutput({tag, " RX_DATA"},  RX_DATA,  0);
        checkOutput({tag, " TX_COUNT"}, TX_COUNT, 0);
        checkOutput({tag, " TX_READY"}, TX_READY, 1);
    endtask

    initial begin
        RESET    = 1'b1;
        ACK_TX   = 1'b0;
        REQ_RX   = 1'b0;
        RX_READY = 1'b0;
        ADDR_OUT = '0;
        DATA_OUT = '0;
        applyStimulus(1'b0, 8'h00, 32'h0);
        #12;
        checkResetState("reset");
        step();
        RESET = 1'b0;
        step();

        // Single message, ack after three cycles of request
        applyStimulus(1'b1, 8'hab, 32'habcdef12);
        step();
        applyStimulus(1'b0, 8'h00, 32'h0);
        checkOutput("t1 count after push", TX_COUNT, 1);
        checkOutput("t1 req before load", REQ_TX, 0);
        step();
        checkOutput("t1 req high", REQ_TX, 1);
        checkOutput("t1 addr_in", ADDR_IN, 8'hab);
        checkOutput("t1 data_in", DATA_IN, 32'habcdef12);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("t1 req held", REQ_TX, 1);
            checkOutput("t1 addr held", ADDR_IN, 8'hab);
            checkOutput("t1 data held", DATA_IN, 32'habcdef12);
        end
        ACK_TX = 1'b1;
        step();
        checkOutput("t1 req dropped", REQ_TX, 0);
        checkOutput("t1 count popped", TX_COUNT, 0);
        ACK_TX = 1'b0;
        step();
        step();
        checkOutput("t1 stays idle", REQ_TX, 0);

        // Fill the queue past capacity with the node stalled
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i), 32'ha0000000 + 32'(i));
            step();
            checkOutput("t2 count", TX_COUNT, (i < 4) ? i + 1 : 4);
            checkOutput("t2 ready", TX_READY, (i < 3) ? 1 : 0);
        end
        applyStimulus(1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 4; i++) begin
            waitReqTx(1'b1, "t2 req rise");
            checkOutput("t2 order addr", ADDR_IN, 8'h10 + 8'(i));
            checkOutput("t2 order data", DATA_IN, 32'ha0000000 + 32'(i));
            ACK_TX = 1'b1;
            step();
            checkOutput("t2 req fall", REQ_TX, 0);
            checkOutput("t2 count drain", TX_COUNT, 3 - i);
            step();
            checkOutput("t2 no reassert while ack high", REQ_TX, 0);
            ACK_TX = 1'b0;
            step();
            checkOutput("t2 idle gap", REQ_TX, 0);
        end
        step();
        checkOutput("t2 empty no req", REQ_TX, 0);

        // Receive with user ready
        RX_READY = 1'b1;
        ADDR_OUT = 8'hcd;
        DATA_OUT = 32'h12345678;
        REQ_RX   = 1'b1;
        step();
        checkOutput("t3 ack_rx", ACK_RX, 1);
        checkOutput("t3 rx_valid", RX_VALID, 1);
        checkOutput("t3 rx_addr", RX_ADDR, 8'hcd);
        checkOutput("t3 rx_data", RX_DATA, 32'h12345678);
        REQ_RX = 1'b0;
        step();
        checkOutput("t3 ack_rx drop", ACK_RX, 0);
        checkOutput("t3 rx_valid popped", RX_VALID, 0);
        RX_READY = 1'b0;

        // Backpressure: second request waits for the first to be consumed
        ADDR_OUT = 8'h21;
        DATA_OUT = 32'h11112222;
        REQ_RX   = 1'b1;
        step();
        checkOutput("t4 first ack", ACK_RX, 1);
        REQ_RX = 1'b0;
        step();
        checkOutput("t4 first ack drop", ACK_RX, 0);
        ADDR_OUT = 8'h42;
        DATA_OUT = 32'h33334444;
        REQ_RX   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t4 held off", ACK_RX, 0);
            checkOutput("t4 first addr kept", RX_ADDR, 8'h21);
            checkOutput("t4 first data kept", RX_DATA, 32'h11112222);
            checkOutput("t4 first valid kept", RX_VALID, 1);
        end
        RX_READY = 1'b1;
        step();
        RX_READY = 1'b0;
        checkOutput("t4 second ack", ACK_RX, 1);
        checkOutput("t4 second valid", RX_VALID, 1);
        checkOutput("t4 second addr", RX_ADDR, 8'h42);
        checkOutput("t4 second data", RX_DATA, 32'h33334444);
        REQ_RX = 1'b0;
        step();
        checkOutput("t4 second ack drop", ACK_RX, 0);
        RX_READY = 1'b1;
        step();
        RX_READY = 1'b0;
        checkOutput("t4 popped", RX_VALID, 0);

        // Concurrent transmit push and receive request
        applyStimulus(1'b1, 8'h5a, 32'hdeadbeef);
        ADDR_OUT = 8'h77;
        DATA_OUT = 32'hcafef00d;
        REQ_RX   = 1'b1;
        step();
        applyStimulus(1'b0, 8'h00, 32'h0);
        checkOutput("t5 ack_rx", ACK_RX, 1);
        checkOutput("t5 rx_addr", RX_ADDR, 8'h77);
        checkOutput("t5 tx count", TX_COUNT, 1);
        step();
        checkOutput("t5 req_tx", REQ_TX, 1);
        checkOutput("t5 addr_in", ADDR_IN, 8'h5a);
        checkOutput("t5 data_in", DATA_IN, 32'hdeadbeef);
        REQ_RX = 1'b0;
        ACK_TX = 1'b1;
        step();
        checkOutput("t5 req_tx drop", REQ_TX, 0);
        checkOutput("t5 ack_rx drop", ACK_RX, 0);
        checkOutput("t5 tx count 0", TX_COUNT, 0);
        checkOutput("t5 rx_data kept", RX_DATA, 32'hcafef00d);
        ACK_TX   = 1'b0;
        RX_READY = 1'b1;
        step();
        RX_READY = 1'b0;
        checkOutput("t5 rx popped", RX_VALID, 0);
        step();

        // Reset in the middle of both handshakes
        applyStimulus(1'b1, 8'h61, 32'h00000061);
        step();
        applyStimulus(1'b1, 8'h62, 32'h00000062);
        ADDR_OUT = 8'h99;
        DATA_OUT = 32'h99999999;
        REQ_RX   = 1'b1;
        step();
        applyStimulus(1'b0, 8'h00, 32'h0);
        checkOutput("t6 pre req_tx", REQ_TX, 1);
        checkOutput("t6 pre ack_rx", ACK_RX, 1);
        checkOutput("t6 pre count", TX_COUNT, 2);
        #3;
        RESET  = 1'b1;
        REQ_RX = 1'b0;
        #1;
        checkResetState("t6 async");
        step();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("t6 idle req_tx", REQ_TX, 0);
            checkOutput("t6 idle count", TX_COUNT, 0);
            checkOutput("t6 idle ack_rx", ACK_RX, 0);
            checkOutput("t6 idle rx_valid", RX_VALID, 0);
        end
        applyStimulus(1'b1, 8'h70, 32'h70707070);
        step();
        applyStimulus(1'b0, 8'h00, 32'h0);
        waitReqTx(1'b1, "t6 new req");
        checkOutput("t6 new addr", ADDR_IN, 8'h70);
        ACK_TX = 1'b1;
        step();
        ACK_TX = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule
